pipelined_adder_unit: RTL and testbench

//  Parametrised successor to the single-cycle adder wrapper. Native RTL, no black box.

---
 rtl/pipelined_adder_unit.sv | 148 ++++++++++++++
 tb/tb_pipelined_adder_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_unit.sv
// pipelined_adder_unit
// Add/sub with optional signed saturation, carried through STAGES registered
// slots with valid/ready flow control on both sides. The arithmetic result is
// formed from the input beat and captured in the first slot; later slots only
// delay it. A slot refills when it is empty or when the slot after it is moving
// on, so a stalled output lets upstream beats close up any gaps.
module pipelined_adder_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic [1:0]       io_in_op,
    input  logic [TAG_W-1:0] io_in_tag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_carry,
    output logic             io_out_ovf,
    output logic [TAG_W-1:0] io_out_tag
);

    localparam int MSB = WIDTH - 1;

    // Per-slot state
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] ovf_q,   ovf_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    // Slot load enables; room_s accumulates "something downstream can move"
    logic [STAGES-1:0] load_s;
    logic              room_s;

    // Arithmetic on the incoming beat
    logic             is_sub_s;
    logic             is_sat_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] wrap_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;

    // Form the wrapped sum/difference, carry/borrow, overflow and saturated result
    always_comb begin
        is_sub_s = io_in_op[0];
        is_sat_s = io_in_op[1];
        // Subtraction is a + ~b + 1; the ~b operand also gives the correct
        // signed-overflow test for the true difference (including b = min).
        b_eff_s  = is_sub_s ? ~io_in_b : io_in_b;
        wide_s   = {1'b0, io_in_a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
        wrap_s   = wide_s[WIDTH-1:0];
        carry_s  = is_sub_s ? ~wide_s[WIDTH] : wide_s[WIDTH];
        ovf_s    = (io_in_a[MSB] == b_eff_s[MSB]) && (wrap_s[MSB] != io_in_a[MSB]);
        if (is_sat_s && ovf_s) begin
            res_s = io_in_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = wrap_s;
        end
    end

    // A slot may load when it or any slot after it is empty, or the output is being taken
    always_comb begin
        load_s = '0;
        room_s = io_out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room_s    = room_s | ~valid_q[k];
            load_s[k] = room_s;
        end
    end

    // Next-state for every slot: hold by default, shift in from the previous slot when loading
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            ovf_d[k]   = ovf_q[k];
            sum_d[k]   = sum_q[k];
            tag_d[k]   = tag_q[k];
        end
        if (load_s[0]) begin
            valid_d[0] = io_in_valid;
        end else begin
            valid_d[0] = valid_q[0];
        end
        if (load_s[0] && io_in_valid) begin
            carry_d[0] = carry_s;
            ovf_d[0]   = ovf_s;
            sum_d[0]   = res_s;
            tag_d[0]   = io_in_tag;
        end else begin
            carry_d[0] = carry_q[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_s[k]) begin
                valid_d[k] = valid_q[k-1];
            end else begin
                valid_d[k] = valid_q[k];
            end
            if (load_s[k] && valid_q[k-1]) begin
                carry_d[k] = carry_q[k-1];
                ovf_d[k]   = ovf_q[k-1];
                sum_d[k]   = sum_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end else begin
                carry_d[k] = carry_q[k];
            end
        end
    end

    // Slot registers; reset discards every in-flight beat immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign io_in_ready  = load_s[0];
    assign io_out_valid = valid_q[STAGES-1];
    assign io_out_sum   = sum_q[STAGES-1];
    assign io_out_carry = carry_q[STAGES-1];
    assign io_out_ovf   = ovf_q[STAGES-1];
    assign io_out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_unit.sv
// Testbench for pipelined_adder_unit: scoreboard queue filled on accepted input
// beats, drained by an independent monitor on every output transfer.
module tb_pipelined_adder_unit;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a = '0;
    logic [WIDTH-1:0] io_in_b = '0;
    logic [1:0]       io_in_op = 2'd0;
    logic [TAG_W-1:0] io_in_tag = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b1;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_carry;
    logic             io_out_ovf;
    logic [TAG_W-1:0] io_out_tag;

    pipelined_adder_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_op(io_in_op), .io_in_tag(io_in_tag),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_sum(io_out_sum), .io_out_carry(io_out_carry),
        .io_out_ovf(io_out_ovf), .io_out_tag(io_out_tag)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_exp;
    exp_t mon_e, mon_cur, hold_val;
    logic hold_pend = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [31:0] s, logic c, logic o, logic [3:0] t);
        exp_t e;
        e.sum = s; e.carry = c; e.ovf = o; e.tag = t;
        return e;
    endfunction

    // Reference: true signed result compared with the 32-bit signed range
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [3:0] t);
        exp_t   e;
        longint tv;
        logic [63:0] u;
        e.tag = t;
        if (op[0]) begin
            tv      = longint'($signed(a)) - longint'($signed(b));
            e.carry = (a < b);
            e.sum   = a - b;
        end else begin
            tv      = longint'($signed(a)) + longint'($signed(b));
            u       = 64'(a) + 64'(b);
            e.carry = u[32];
            e.sum   = a + b;
        end
        e.ovf = (tv > 64'sd2147483647) || (tv < -64'sd2147483648);
        if (op[1] && e.ovf) e.sum = (tv > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(0, 3));
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop and compare on each output transfer, check hold during stalls
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                hold_pend = 1'b0;
            end else begin
                mon_cur = mk(io_out_sum, io_out_carry, io_out_ovf, io_out_tag);
                if (hold_pend) begin
                    chk("hold_valid", io_out_valid, 1);
                    chk("hold_data", mon_cur, hold_val);
                end
                hold_pend = 1'b0;
                if (io_out_valid && io_out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output_tag", {60'd0, io_out_tag}, 64'hDEAD);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("tag", io_out_tag, mon_e.tag);
                        chk("sum", io_out_sum, mon_e.sum);
                        chk("carry", io_out_carry, mon_e.carry);
                        chk("ovf", io_out_ovf, mon_e.ovf);
                    end
                end else if (io_out_valid) begin
                    hold_pend = 1'b1;
                    hold_val  = mon_cur;
                end
            end
        end
    end

    task automatic to_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(output bit acc);
        @(negedge clock);
        acc = io_in_valid && io_in_ready;
        if (acc) exp_q.push_back(pend_exp);
    endtask

    task automatic set_beat(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [3:0] t, exp_t e);
        io_in_a = a; io_in_b = b; io_in_op = op; io_in_tag = t;
        pend_exp = e;
        io_in_valid = 1'b1;
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [3:0] t, exp_t e);
        bit acc;
        int n;
        to_edge();
        set_beat(a, b, op, t, e);
        sample(acc);
        n = 0;
        while (!acc && n < 50) begin
            to_edge();
            sample(acc);
            n++;
        end
        chk("send_accept", acc, 1);
        to_edge();
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic [3:0]  rt;

        // Reset state
        #12;
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_out_sum", io_out_sum, 0);
        chk("rst_out_tag", io_out_tag, 0);
        chk("rst_out_carry_ovf", {io_out_carry, io_out_ovf}, 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: simple add, latency of STAGES cycles
        to_edge();
        io_out_ready = 1'b1;
        set_beat(32'd5, 32'd7, 2'b00, 4'd3, mk(32'd12, 1'b0, 1'b0, 4'd3));
        sample(acc);
        chk("t1_accept", acc, 1);
        to_edge();
        io_in_valid = 1'b0;
        @(negedge clock);
        chk("t1_not_early", io_out_valid, 0);
        @(negedge clock);
        chk("t1_valid_at_latency", io_out_valid, 1);
        drain();

        // 2-3: overflow, saturation and borrow corners
        send(32'h7FFF_FFFF, 32'd1, 2'b00, 4'd4, mk(32'h8000_0000, 1'b0, 1'b1, 4'd4));
        send(32'h7FFF_FFFF, 32'd1, 2'b10, 4'd5, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 4'd5));
        send(32'd0, 32'd1, 2'b01, 4'd6, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 4'd6));
        send(32'h8000_0000, 32'd1, 2'b11, 4'd7, mk(32'h8000_0000, 1'b0, 1'b1, 4'd7));
        send(32'd0, 32'h8000_0000, 2'b01, 4'd8, mk(32'h8000_0000, 1'b1, 1'b1, 4'd8));
        send(32'd0, 32'h8000_0000, 2'b11, 4'd9, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 4'd9));
        send(32'hFFFF_FFFF, 32'd1, 2'b00, 4'd10, mk(32'd0, 1'b1, 1'b0, 4'd10));
        drain();

        // 4: stream tags 1..5 with the output stalled for 4 cycles
        idx = 0;
        for (int c = 0; c < 60 && idx < 5; c++) begin
            to_edge();
            io_out_ready = (c >= 4);
            ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
            set_beat(ra, rb, rop, 4'(idx + 1), model(ra, rb, rop, 4'(idx + 1)));
            sample(acc);
            if (c == 2 || c == 3) chk("t4_in_ready_when_full", io_in_ready, 0);
            if (c == 3) chk("t4_accepted_before_release", idx, 2);
            if (acc) idx++;
        end
        chk("t4_all_accepted", idx, 5);
        to_edge();
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        drain();

        // 5: 20 back-to-back beats at full throughput
        for (int c = 0; c < 22; c++) begin
            to_edge();
            if (c < 20) begin
                ra = rnd_operand(); rb = rnd_operand(); rop = 2'($urandom_range(0, 3));
                set_beat(ra, rb, rop, 4'(c), model(ra, rb, rop, 4'(c)));
            end else begin
                io_in_valid = 1'b0;
            end
            sample(acc);
            if (c < 20) chk("t5_in_ready", io_in_ready, 1);
            chk("t5_out_valid", io_out_valid, (c >= STAGES && c < 20 + STAGES));
        end
        drain();

        // Random traffic with random back-pressure
        acc = 1'b1;
        for (int c = 0; c < 300; c++) begin
            to_edge();
            io_out_ready = ($urandom_range(0, 3) != 0);
            if (!io_in_valid || acc) begin
                if ($urandom_range(0, 4) != 0) begin
                    ra = rnd_operand(); rb = rnd_operand();
                    rop = 2'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 15));
                    set_beat(ra, rb, rop, rt, model(ra, rb, rop, rt));
                end else begin
                    io_in_valid = 1'b0;
                end
            end
            sample(acc);
        end
        to_edge();
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        drain();

        // 6: reset with two beats in flight
        for (int c = 0; c < 2; c++) begin
            to_edge();
            io_out_ready = 1'b0;
            ra = $urandom; rb = $urandom;
            set_beat(ra, rb, 2'b00, 4'(11 + c), model(ra, rb, 2'b00, 4'(11 + c)));
            sample(acc);
            chk("t6_accept", acc, 1);
        end
        to_edge();
        io_in_valid = 1'b0;
        @(negedge clock);
        chk("t6_full_before_reset", io_out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_out_valid", io_out_valid, 0);
        exp_q.delete();
        io_out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("t6_no_stale_output", io_out_valid, 0);
            if (c == 0) chk("t6_in_ready_after_release", io_in_ready, 1);
        end
        send(32'd100, 32'd58, 2'b01, 4'd15, mk(32'd42, 1'b0, 1'b0, 4'd15));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
